// File: rtl/mci_pkg.sv
// Shared types for the MCI AXI subordinate arbiter: FSM states and the
// latched CIF request payload.
package mci_pkg;

  localparam int unsigned CIF_AW = 32;
  localparam int unsigned CIF_DW = 32;
  localparam int unsigned CIF_SW = CIF_DW / 8;
  localparam int unsigned CIF_UW = 32;
  localparam int unsigned CIF_IW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              write;
    logic [CIF_AW-1:0] addr;
    logic [CIF_DW-1:0] wdata;
    logic [CIF_SW-1:0] wstrb;
    logic [CIF_UW-1:0] user;
    logic [CIF_IW-1:0] id;
  } cif_req_t;

endpackage

// File: rtl/mci_rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant flag moves only when en
// is high and someone is granted. Requester 1 is treated as last granted
// out of reset, so requester 0 wins the first tie.
module mci_rr_arb2 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt_c
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_c  = 2'b00;
    last_d = last_q;
    if (req[0] && (!req[1] || last_q)) begin
      gnt_c = 2'b01;
    end else if (req[1]) begin
      gnt_c = 2'b10;
    end
    if (en && (gnt_c != 2'b00)) begin
      last_d = gnt_c[1];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mci_axi_sub_arb.sv
// Round-robin merge of AXI write/read requests into a single-outstanding CIF
// request toward the MCI decoder, returning the result on the owner's channel.
module mci_axi_sub_arb
  import mci_pkg::*;
#(
  parameter int unsigned AW = CIF_AW,
  parameter int unsigned DW = CIF_DW,
  parameter int unsigned UW = CIF_UW,
  parameter int unsigned IW = CIF_IW
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            wr_req_valid,
  output logic            wr_req_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_wdata,
  input  logic [DW/8-1:0] wr_wstrb,
  input  logic [UW-1:0]   wr_user,
  input  logic [IW-1:0]   wr_id,
  output logic            wr_resp_valid,
  input  logic            wr_resp_ready,
  output logic [IW-1:0]   wr_resp_id,
  output logic            wr_resp_err,
  input  logic            rd_req_valid,
  output logic            rd_req_ready,
  input  logic [AW-1:0]   rd_addr,
  input  logic [UW-1:0]   rd_user,
  input  logic [IW-1:0]   rd_id,
  output logic            rd_resp_valid,
  input  logic            rd_resp_ready,
  output logic [DW-1:0]   rd_rdata,
  output logic [IW-1:0]   rd_resp_id,
  output logic            rd_resp_err,
  output logic            cif_dv,
  output logic            cif_write,
  output logic [AW-1:0]   cif_addr,
  output logic [DW-1:0]   cif_wdata,
  output logic [DW/8-1:0] cif_wstrb,
  output logic [UW-1:0]   cif_user,
  output logic [IW-1:0]   cif_id,
  input  logic            cif_hold,
  input  logic [DW-1:0]   cif_rdata,
  input  logic            cif_error
);

  localparam int unsigned SW = DW / 8;

  arb_state_e    state_q, state_d;
  cif_req_t      req_q, req_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          dv_q, dv_d;
  logic          wr_rv_q, wr_rv_d;
  logic          rd_rv_q, rd_rv_d;
  logic [1:0]    gnt_c;
  logic          idle_c;

  assign idle_c = (state_q == IDLE);

  mci_rr_arb2 u_arb (
    .clk   (clk),
    .rst_b (rst_b),
    .req   ({rd_req_valid, wr_req_valid}),
    .en    (idle_c),
    .gnt_c (gnt_c)
  );

  assign wr_req_ready = idle_c & gnt_c[0];
  assign rd_req_ready = idle_c & gnt_c[1];

  // Next state, holding-register capture and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_c[0]) begin
          req_d.write = 1'b1;
          req_d.addr  = CIF_AW'(wr_addr);
          req_d.wdata = CIF_DW'(wr_wdata);
          req_d.wstrb = CIF_SW'(wr_wstrb);
          req_d.user  = CIF_UW'(wr_user);
          req_d.id    = CIF_IW'(wr_id);
          state_d     = REQ;
        end else if (gnt_c[1]) begin
          req_d.write = 1'b0;
          req_d.addr  = CIF_AW'(rd_addr);
          req_d.wdata = '0;
          req_d.wstrb = '0;
          req_d.user  = CIF_UW'(rd_user);
          req_d.id    = CIF_IW'(rd_id);
          state_d     = REQ;
        end
      end
      REQ: begin
        if (!cif_hold) begin
          err_d = cif_error;
          if (!req_q.write) begin
            rdata_d = cif_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (req_q.write ? wr_resp_ready : rd_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dv_d    = (state_d == REQ);
    wr_rv_d = (state_d == RESP) &&  req_d.write;
    rd_rv_d = (state_d == RESP) && !req_d.write;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      dv_q    <= 1'b0;
      wr_rv_q <= 1'b0;
      rd_rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      dv_q    <= dv_d;
      wr_rv_q <= wr_rv_d;
      rd_rv_q <= rd_rv_d;
    end
  end

  assign cif_dv        = dv_q;
  assign cif_write     = req_q.write;
  assign cif_addr      = AW'(req_q.addr);
  assign cif_wdata     = DW'(req_q.wdata);
  assign cif_wstrb     = SW'(req_q.wstrb);
  assign cif_user      = UW'(req_q.user);
  assign cif_id        = IW'(req_q.id);
  assign wr_resp_valid = wr_rv_q;
  assign wr_resp_id    = IW'(req_q.id);
  assign wr_resp_err   = err_q;
  assign rd_resp_valid = rd_rv_q;
  assign rd_rdata      = rdata_q;
  assign rd_resp_id    = IW'(req_q.id);
  assign rd_resp_err   = err_q;

  // Single-owner invariants.
  a_dv_in_req: assert property (@(posedge clk) disable iff (!rst_b)
    cif_dv |-> (state_q == REQ));
  a_cif_stable: assert property (@(posedge clk) disable iff (!rst_b)
    (cif_dv && cif_hold) |=> $stable({cif_dv, cif_write, cif_addr, cif_wdata,
                                      cif_wstrb, cif_user, cif_id}));
  a_resp_mutex: assert property (@(posedge clk) disable iff (!rst_b)
    !(wr_resp_valid && rd_resp_valid));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_b)
    (wr_req_ready || rd_req_ready) |-> (state_q == IDLE));

endmodule

// File: tb/tb_mci_axi_sub_arb.sv
// Bench for mci_axi_sub_arb: directed scenarios plus random traffic, all
// checked against a transaction-level model of the arbitration rules.
module tb_mci_axi_sub_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned UW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned SW = DW / 8;
  localparam int S_NONE  = 0;
  localparam int S_ISSUE = 1;
  localparam int S_RESP  = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata;
  logic [SW-1:0] wr_wstrb;
  logic [UW-1:0] wr_user;
  logic [IW-1:0] wr_id;
  logic          wr_resp_valid, wr_resp_ready;
  logic [IW-1:0] wr_resp_id;
  logic          wr_resp_err;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic [UW-1:0] rd_user;
  logic [IW-1:0] rd_id;
  logic          rd_resp_valid, rd_resp_ready;
  logic [DW-1:0] rd_rdata;
  logic [IW-1:0] rd_resp_id;
  logic          rd_resp_err;
  logic          cif_dv, cif_write;
  logic [AW-1:0] cif_addr;
  logic [DW-1:0] cif_wdata;
  logic [SW-1:0] cif_wstrb;
  logic [UW-1:0] cif_user;
  logic [IW-1:0] cif_id;
  logic          cif_hold;
  logic [DW-1:0] cif_rdata;
  logic          cif_error;

  always #5 clk = ~clk;

  mci_axi_sub_arb #(.AW(AW), .DW(DW), .UW(UW), .IW(IW)) dut (
    .clk(clk), .rst_b(rst_b),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
    .wr_user(wr_user), .wr_id(wr_id),
    .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
    .wr_resp_id(wr_resp_id), .wr_resp_err(wr_resp_err),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr(rd_addr), .rd_user(rd_user), .rd_id(rd_id),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_rdata(rd_rdata), .rd_resp_id(rd_resp_id), .rd_resp_err(rd_resp_err),
    .cif_dv(cif_dv), .cif_write(cif_write), .cif_addr(cif_addr),
    .cif_wdata(cif_wdata), .cif_wstrb(cif_wstrb), .cif_user(cif_user),
    .cif_id(cif_id), .cif_hold(cif_hold), .cif_rdata(cif_rdata),
    .cif_error(cif_error)
  );

  typedef struct packed {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
  } txn_t;

  int            n_checks = 0;
  int            n_errors = 0;
  int            m_stage;
  bit            m_last_rd;
  txn_t          m_cur;
  logic          m_err;
  logic [DW-1:0] m_rdata;
  bit            grant_log[$];
  bit            rand_mode = 1'b0;

  logic          obs_dv, obs_write, obs_wr_rv, obs_rd_rv, obs_wr_rdy, obs_rd_rdy;
  logic          obs_wr_err, obs_rd_err;
  logic [IW-1:0] obs_wr_id, obs_rd_id;
  logic [DW-1:0] obs_rdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [UW-1:0] u, input logic [IW-1:0] i);
    wr_req_valid = 1'b1; wr_addr = a; wr_wdata = d; wr_wstrb = s; wr_user = u; wr_id = i;
  endtask

  task automatic put_rd(input logic [AW-1:0] a, input logic [UW-1:0] u, input logic [IW-1:0] i);
    rd_req_valid = 1'b1; rd_addr = a; rd_user = u; rd_id = i;
  endtask

  task automatic drive_random();
    cif_hold      = ($urandom_range(0, 3) == 0);
    cif_rdata     = $urandom;
    cif_error     = ($urandom_range(0, 7) == 0);
    wr_resp_ready = ($urandom_range(0, 3) != 0);
    rd_resp_ready = ($urandom_range(0, 3) != 0);
    if (!wr_req_valid && $urandom_range(0, 2) == 0)
      put_wr($urandom, $urandom, SW'($urandom), $urandom, IW'($urandom));
    if (!rd_req_valid && $urandom_range(0, 2) == 0)
      put_rd($urandom, $urandom, IW'($urandom));
  endtask

  // One clock: check outputs against the model at negedge, advance the model,
  // then retire accepted requests just after the next posedge.
  task automatic tick();
    logic e_wr_rdy, e_rd_rdy;
    bit   wa, ra;
    wa = 1'b0; ra = 1'b0;
    @(negedge clk);
    e_wr_rdy = (m_stage == S_NONE) && wr_req_valid && (!rd_req_valid || m_last_rd);
    e_rd_rdy = (m_stage == S_NONE) && rd_req_valid && !e_wr_rdy;
    check_eq("wr_req_ready", wr_req_ready, e_wr_rdy);
    check_eq("rd_req_ready", rd_req_ready, e_rd_rdy);
    check_eq("cif_dv", cif_dv, m_stage == S_ISSUE);
    if (m_stage == S_ISSUE) begin
      check_eq("cif_write", cif_write, m_cur.w);
      check_eq("cif_addr", cif_addr, m_cur.addr);
      check_eq("cif_user", cif_user, m_cur.user);
      check_eq("cif_id", cif_id, m_cur.id);
      if (m_cur.w) begin
        check_eq("cif_wdata", cif_wdata, m_cur.wdata);
        check_eq("cif_wstrb", cif_wstrb, m_cur.strb);
      end
    end
    check_eq("wr_resp_valid", wr_resp_valid, (m_stage == S_RESP) && m_cur.w);
    check_eq("rd_resp_valid", rd_resp_valid, (m_stage == S_RESP) && !m_cur.w);
    if (m_stage == S_RESP && m_cur.w) begin
      check_eq("wr_resp_id", wr_resp_id, m_cur.id);
      check_eq("wr_resp_err", wr_resp_err, m_err);
    end
    if (m_stage == S_RESP && !m_cur.w) begin
      check_eq("rd_rdata", rd_rdata, m_rdata);
      check_eq("rd_resp_id", rd_resp_id, m_cur.id);
      check_eq("rd_resp_err", rd_resp_err, m_err);
    end
    obs_dv = cif_dv; obs_write = cif_write;
    obs_wr_rv = wr_resp_valid; obs_rd_rv = rd_resp_valid;
    obs_wr_rdy = wr_req_ready; obs_rd_rdy = rd_req_ready;
    obs_wr_id = wr_resp_id; obs_rd_id = rd_resp_id;
    obs_wr_err = wr_resp_err; obs_rd_err = rd_resp_err; obs_rdata = rd_rdata;
    case (m_stage)
      S_NONE: begin
        if (e_wr_rdy) begin
          m_cur = '{w: 1'b1, addr: wr_addr, wdata: wr_wdata, strb: wr_wstrb, user: wr_user, id: wr_id};
          m_last_rd = 1'b0; grant_log.push_back(1'b0); m_stage = S_ISSUE; wa = 1'b1;
        end else if (e_rd_rdy) begin
          m_cur = '{w: 1'b0, addr: rd_addr, wdata: '0, strb: '0, user: rd_user, id: rd_id};
          m_last_rd = 1'b1; grant_log.push_back(1'b1); m_stage = S_ISSUE; ra = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!cif_hold) begin
          m_err = cif_error;
          if (!m_cur.w) m_rdata = cif_rdata;
          m_stage = S_RESP;
        end
      end
      default: begin
        if (m_cur.w ? wr_resp_ready : rd_resp_ready) m_stage = S_NONE;
      end
    endcase
    @(posedge clk);
    #1;
    if (wa) wr_req_valid = 1'b0;
    if (ra) rd_req_valid = 1'b0;
    if (rand_mode) drive_random();
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (m_stage == S_NONE && !wr_req_valid && !rd_req_valid) break;
      tick();
    end
    check_eq("drain_idle", m_stage == S_NONE && !wr_req_valid && !rd_req_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dv_cnt, lat, rdy_seen, rv_cnt;
    bit   seen;
    rst_b = 1'b0;
    wr_req_valid = 1'b0; wr_addr = '0; wr_wdata = '0; wr_wstrb = '0; wr_user = '0; wr_id = '0;
    rd_req_valid = 1'b0; rd_addr = '0; rd_user = '0; rd_id = '0;
    wr_resp_ready = 1'b1; rd_resp_ready = 1'b1;
    cif_hold = 1'b0; cif_rdata = '0; cif_error = 1'b0;
    m_stage = S_NONE; m_last_rd = 1'b1; m_cur = '0; m_err = 1'b0; m_rdata = '0;
    #1;
    check_eq("rst_cif_dv", cif_dv, 1'b0);
    check_eq("rst_cif_write", cif_write, 1'b0);
    check_eq("rst_cif_addr", cif_addr, '0);
    check_eq("rst_cif_id", cif_id, '0);
    check_eq("rst_wr_resp_valid", wr_resp_valid, 1'b0);
    check_eq("rst_rd_resp_valid", rd_resp_valid, 1'b0);
    check_eq("rst_rd_rdata", rd_rdata, '0);
    check_eq("rst_resp_err", {wr_resp_err, rd_resp_err}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    // Single write, no stall.
    put_wr(32'h0000_0100, 32'hA5A5_A5A5, 4'hF, 32'h0000_0011, 8'h03);
    tick(); check_eq("t1_accept", obs_wr_rdy, 1'b1);
    tick(); check_eq("t1_dv", obs_dv, 1'b1); check_eq("t1_write", obs_write, 1'b1);
    tick(); check_eq("t1_resp", obs_wr_rv, 1'b1);
    check_eq("t1_resp_id", obs_wr_id, 8'h03); check_eq("t1_resp_err", obs_wr_err, 1'b0);
    tick(); check_eq("t1_dv_once", obs_dv, 1'b0);

    // Read stalled by hold for 4 cycles.
    drain();
    cif_hold = 1'b1;
    put_rd(32'h0000_0200, 32'h0000_0022, 8'h05);
    tick(); check_eq("t2_accept", obs_rd_rdy, 1'b1);
    dv_cnt = 0; lat = 0;
    for (int k = 1; k <= 10; k++) begin
      cif_hold  = (k <= 4);
      cif_rdata = (k == 5) ? 32'hDEAD_BEEF : 32'h0BAD_0000 + 32'(k);
      tick();
      if (obs_dv) dv_cnt++;
      if (obs_rd_rv) begin lat = k; break; end
    end
    check_eq("t2_dv_cycles", 64'(dv_cnt), 64'd5);
    check_eq("t2_latency", 64'(lat), 64'd6);
    check_eq("t2_rdata", obs_rdata, 32'hDEAD_BEEF);
    cif_hold = 1'b0;

    // Simultaneous requests alternate, write first after a read.
    drain();
    grant_log.delete();
    put_wr(32'h10, 32'h1, 4'h3, 32'h0, 8'h10);
    put_rd(32'h20, 32'h0, 8'h20);
    for (int k = 0; k < 60; k++) begin
      tick();
      if (grant_log.size() < 4) begin
        if (!wr_req_valid) put_wr(32'h10 + 32'(k), $urandom, 4'hF, 32'h0, 8'h10 + 8'(k));
        if (!rd_req_valid) put_rd(32'h20 + 32'(k), 32'h0, 8'h20 + 8'(k));
      end
      if (grant_log.size() >= 4 && !wr_req_valid && !rd_req_valid && m_stage == S_NONE) break;
    end
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t3_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : 1'bx, 64'(i % 2));

    // Decoder miss reported as read error.
    drain();
    cif_error = 1'b1;
    put_rd(32'h0030_0000, 32'h0, 8'h07);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_rd_rv) begin seen = 1'b1; break; end
    end
    check_eq("t4_resp_seen", seen, 1'b1);
    check_eq("t4_err", obs_rd_err, 1'b1);
    check_eq("t4_id", obs_rd_id, 8'h07);
    cif_error = 1'b0;

    // Write response backpressure blocks a pending read.
    drain();
    put_wr(32'h40, 32'h1234_5678, 4'h1, 32'h5, 8'h0A);
    tick(); check_eq("t5_accept", obs_wr_rdy, 1'b1);
    put_rd(32'h44, 32'h6, 8'h0B);
    wr_resp_ready = 1'b0;
    rdy_seen = 0; rv_cnt = 0;
    tick(); rdy_seen += int'(obs_rd_rdy);
    for (int k = 0; k < 5; k++) begin
      tick(); rdy_seen += int'(obs_rd_rdy); rv_cnt += int'(obs_wr_rv);
    end
    wr_resp_ready = 1'b1;
    tick(); rdy_seen += int'(obs_rd_rdy);
    check_eq("t5_blocked", 64'(rdy_seen), 64'd0);
    check_eq("t5_stall_valid", 64'(rv_cnt), 64'd5);
    tick(); check_eq("t5_read_accept", obs_rd_rdy, 1'b1);

    // Reset during a held request.
    drain();
    cif_hold = 1'b1;
    put_wr(32'h80, 32'hCAFE_F00D, 4'hF, 32'h9, 8'h0C);
    tick();
    tick(); check_eq("t6_in_req", obs_dv, 1'b1);
    rst_b = 1'b0;
    #1;
    check_eq("t6_rst_dv", cif_dv, 1'b0);
    check_eq("t6_rst_addr", cif_addr, '0);
    check_eq("t6_rst_write", cif_write, 1'b0);
    check_eq("t6_rst_id", cif_id, '0);
    check_eq("t6_rst_resp", {wr_resp_valid, rd_resp_valid}, 2'b00);
    check_eq("t6_rst_ready", {wr_req_ready, rd_req_ready}, 2'b00);
    m_stage = S_NONE; m_last_rd = 1'b1;
    cif_hold = 1'b0;
    @(posedge clk);
    #2 rst_b = 1'b1;
    rv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); rv_cnt += int'(obs_wr_rv) + int'(obs_rd_rv);
    end
    check_eq("t6_no_resp", 64'(rv_cnt), 64'd0);
    put_wr(32'h84, 32'h0102_0304, 4'h6, 32'h1, 8'h0D);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_wr_rv) begin seen = 1'b1; break; end
    end
    check_eq("t6_after_rst", seen, 1'b1);
    check_eq("t6_after_rst_id", obs_wr_id, 8'h0D);

    // Random traffic.
    drain();
    rand_mode = 1'b1;
    drive_random();
    for (int k = 0; k < 2000; k++) tick();
    rand_mode = 1'b0;
    cif_hold = 1'b0; wr_resp_ready = 1'b1; rd_resp_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mci_axi_sub_arb.md
# mci_axi_sub_arb

Upstream neighbour of the MCI AXI subordinate address decoder. It accepts independent, already-parsed AXI write and read requests and arbitrates them round-robin. The winner is serialised into one single-outstanding CIF request toward the decoder (dv/hold handshake). The block captures the decoder's rdata/error on completion and returns it on the matching read or write response channel. It guarantees that at most one transaction is ever in flight to MCI targets, so the decoder's combinational rdata/hold/error are always sampled for exactly one owner.

## Interface
Parameters:
- AW, 32, CIF address width
- DW, 32, data width
- UW, 32, AXI user width
- IW, 8, AXI ID width

Ports:
- clk  in  1  clock
- rst_b  in  1  reset; one clock; reset is asynchronous and active-low
- wr_req_valid / wr_req_ready  in/out  1  write request handshake
- wr_addr  in  AW  write address
- wr_wdata  in  DW  write data
- wr_wstrb  in  DW/8  write byte strobes
- wr_user  in  UW  write AXI user
- wr_id  in  IW  write AXI ID
- wr_resp_valid / wr_resp_ready  out/in  1  write response handshake
- wr_resp_id  out  IW  write response ID
- wr_resp_err  out  1  write response error (SLVERR)
- rd_req_valid / rd_req_ready  in/out  1  read request handshake
- rd_addr  in  AW  read address
- rd_user  in  UW  read AXI user
- rd_id  in  IW  read AXI ID
- rd_resp_valid / rd_resp_ready  out/in  1  read response handshake
- rd_rdata  out  DW  read response data
- rd_resp_id  out  IW  read response ID
- rd_resp_err  out  1  read response error
- cif_dv  out  1  request valid toward decoder
- cif_write  out  1  request is a write
- cif_addr  out  AW  request address
- cif_wdata  out  DW  request write data
- cif_wstrb  out  DW/8  request write strobes
- cif_user  out  UW  request AXI user
- cif_id  out  IW  request AXI ID
- cif_hold  in  1  decoder stall
- cif_rdata  in  DW  decoder read data
- cif_error  in  1  decoder error

## Operation
- FSM has three states: IDLE, REQ, RESP. Reset state is IDLE.
- IDLE:
  - If any request valid, the arbiter grants one side and asserts that side's ready for one cycle.
  - The granted request is latched into holding registers: addr, wdata, wstrb, user, id, write flag, owner. The FSM moves to REQ.
  - Ready is never asserted in REQ or RESP.
- Arbitration:
  - With only one side valid, that side wins.
  - With both valid, the side not granted last wins.
  - The last-grant flag resets to "read", so writes win the first tie.
- REQ:
  - cif_dv=1 and all cif_* outputs driven from the holding registers. They are stable for the whole REQ state.
  - Completion is any cycle with cif_hold=0. In that cycle the block captures cif_rdata (reads only; writes leave the rdata register unchanged) and cif_error, then moves to RESP.
  - cif_hold=1 holds REQ indefinitely; there is no timeout.
- RESP:
  - The owner's resp_valid=1 with the captured id/err/rdata; the other side's resp_valid=0.
  - When resp_ready=1, the FSM returns to IDLE.
  - Response outputs are stable while valid and not ready.
- An address miss at the decoder arrives as cif_error=1 with hold=0 and is reported as resp_err=1 like any other error.
- Reset mid-operation clears the FSM and all holding registers. Any in-flight transaction is dropped with no response.

## Timing
- Reset values: all ready/valid/dv/err outputs 0; cif_write 0; all data, address, user and id outputs 0.
- Accept in cycle N; cif_dv rises at N+1.
- With hold=0 at N+1, resp_valid rises at N+2. With resp_ready=1 at N+2, IDLE at N+3 and the next accept at N+3.
- Minimum 3 cycles per transaction; peak throughput is one transaction per 3 clocks.
- Each cycle of cif_hold=1 adds one cycle of latency.
- Each cycle of resp_ready=0 adds one cycle and blocks both request channels.
- If a request arrives while in RESP, it is accepted no earlier than the cycle IDLE is re-entered.
- The cif_* outputs are registered; the decoder's combinational paths see no logic from the AXI request inputs.

## Structure
- mci_pkg gets:
  - an arbitration state enum {IDLE, REQ, RESP}
  - a packed request struct {write, addr, wdata, wstrb, user, id}, parameterised through package localparams matching the cif_if widths
- One sub-module is natural: mci_rr_arb2, a two-requester round-robin arbiter with a registered last-grant flag, an update-enable input and a one-hot grant output.
- Assertions:
  - cif_dv implies state REQ.
  - cif_* outputs are stable while cif_dv & cif_hold.
  - wr_resp_valid and rd_resp_valid are mutually exclusive.
  - Ready is only ever asserted in IDLE.

## Test plan
- Single write of addr 0x0000_0100, wdata 0xA5A5_A5A5, wstrb 0xF, id 0x3, hold=0 → cif_dv one cycle with matching fields and cif_write=1; wr_resp_valid 2 cycles after accept with id 0x3 and err 0.
- Read with hold=1 for 4 cycles, then cif_rdata=0xDEAD_BEEF → cif_dv high for 5 cycles with fields stable; rd_rdata=0xDEAD_BEEF; total latency 6 cycles.
- Read and write valid simultaneously for 4 back-to-back transactions → grant order W, R, W, R, and never two transactions in flight.
- Read to unmapped addr 0x0030_0000 (decoder returns error=1) → rd_resp_err=1 and rd_resp_id echoed.
- Write response with wr_resp_ready=0 for 5 cycles while rd_req_valid=1 → rd_req_ready stays 0 until the response handshake, then the read is accepted the next cycle.
- rst_b asserted while in REQ with hold=1 → all outputs 0 immediately; no response after reset release; the next request completes normally.
